// File: rtl/shift_norm_pkg.sv
// Shared types and defaults for the shift_normalizer block.
package shift_norm_pkg;

    localparam int unsigned DEFAULT_WIDTH = 48;
    localparam int unsigned DEFAULT_NW    = 4;
    localparam int unsigned MAX_N         = (2 ** DEFAULT_NW) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_norm_datapath.sv
// Shift register, shift counter and the normalized/zero/saturation detect
// for shift_normalizer.
module shift_norm_datapath
    import shift_norm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NW    = DEFAULT_NW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_set_sat,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_mod,
    output logic [WIDTH-1:0] o_data,
    output logic [NW-1:0]    o_count,
    output logic             o_zero,
    output logic             o_sat,
    output logic             o_in_zero,
    output logic             o_norm,
    output logic             o_at_max
);

    // All-ones of the count width is exactly 2**NW - 1.
    localparam logic [NW-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_data;
    logic [NW-1:0]    r_count;
    logic             r_mod;
    logic             r_zero;
    logic             r_sat;

    logic             w_in_zero;
    logic             w_norm;
    logic             w_at_max;

    assign w_in_zero = (i_data == '0);
    assign w_norm    = r_mod ? r_data[WIDTH-1] : r_data[0];
    assign w_at_max  = (r_count == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
            r_mod   <= 1'b0;
            r_zero  <= 1'b0;
            r_sat   <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_mod   <= i_mod;
            r_count <= '0;
            r_zero  <= w_in_zero;
            r_sat   <= 1'b0;
        end else if (i_shift) begin
            r_data <= r_mod ? {r_data[WIDTH-2:0], 1'b0} : {1'b0, r_data[WIDTH-1:1]};
            if (!w_at_max) begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_set_sat) begin
            r_sat <= 1'b1;
        end
    end

    assign o_data    = r_data;
    assign o_count   = r_count;
    assign o_zero    = r_zero;
    assign o_sat     = r_sat;
    assign o_in_zero = w_in_zero;
    assign o_norm    = w_norm;
    assign o_at_max  = w_at_max;

endmodule

// File: rtl/shift_normalizer.sv
// Sequential normalizer: strips trailing (mod=0) or leading (mod=1) zeros one
// bit per clock. Define SHIFT_NORMALIZER_BYPASS_EN to accept on the output handshake edge.
module shift_normalizer
    import shift_norm_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NW    = DEFAULT_NW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [NW-1:0]    out_n,
    output logic             out_zero,
    output logic             out_sat
);

    state_t r_state;
    state_t w_next;

    logic w_load;
    logic w_shift;
    logic w_set_sat;
    logic w_in_zero;
    logic w_norm;
    logic w_at_max;

    shift_norm_datapath #(
        .WIDTH (WIDTH),
        .NW    (NW)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_shift   (w_shift),
        .i_set_sat (w_set_sat),
        .i_data    (in_data),
        .i_mod     (in_mod),
        .o_data    (out_data),
        .o_count   (out_n),
        .o_zero    (out_zero),
        .o_sat     (out_sat),
        .o_in_zero (w_in_zero),
        .o_norm    (w_norm),
        .o_at_max  (w_at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_set_sat = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = w_in_zero ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Normalization wins over saturation so a 15-shift word is not flagged.
                if (w_norm) begin
                    w_next = DONE;
                end else if (w_at_max) begin
                    w_set_sat = 1'b1;
                    w_next    = DONE;
                end else begin
                    w_shift = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
`ifdef SHIFT_NORMALIZER_BYPASS_EN
                    if (in_valid) begin
                        w_load = 1'b1;
                        w_next = w_in_zero ? DONE : SHIFT;
                    end else begin
                        w_next = IDLE;
                    end
`else
                    w_next = IDLE;
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign out_valid = (r_state == DONE);

    // Gated by rst_n so the block never advertises readiness while held in reset.
`ifdef SHIFT_NORMALIZER_BYPASS_EN
    assign in_ready = rst_n && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
`else
    assign in_ready = rst_n && (r_state == IDLE);
`endif

endmodule
